// File: rtl/reg_bus_master.sv
// Register bus master: turns a valid/ready command stream into single-cycle
// register strobes and returns one response per command.
`ifndef REG_ADDR_SZ
`define REG_ADDR_SZ 8
`endif
`ifndef REG_DATA_SZ
`define REG_DATA_SZ 32
`endif

module reg_bus_master #(
    parameter int ADDR_SZ      = `REG_ADDR_SZ,
    parameter int DATA_SZ      = `REG_DATA_SZ,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr,
    input  logic [ADDR_SZ-1:0] cmd_addr,
    input  logic [DATA_SZ-1:0] cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_wr,
    output logic [DATA_SZ-1:0] rsp_rdata,
    output logic               reg_rd_en,
    output logic               reg_wr_en,
    output logic [ADDR_SZ-1:0] reg_addr,
    output logic [DATA_SZ-1:0] reg_wr_data,
    input  logic [DATA_SZ-1:0] reg_rd_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
            $error("reg_bus_master: READ_LATENCY must be in 1..7");
        end
    endgenerate

    logic [1:0]         state;
    logic               wr_q;
    logic [ADDR_SZ-1:0] addr_q;
    logic [DATA_SZ-1:0] wdata_q;
    logic [2:0]         cnt;

    // Strobes decode from state so an asynchronous reset drops them at once.
    assign cmd_ready   = (state == IDLE) && !rst;
    assign rsp_valid   = (state == RESP);
    assign reg_wr_en   = (state == ISSUE) && wr_q;
    assign reg_rd_en   = (state == ISSUE) && !wr_q;
    assign reg_addr    = addr_q;
    assign reg_wr_data = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wr_q    <= cmd_wr;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wr ? cmd_wdata : '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr_q) begin
                        rsp_wr    <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        cnt   <= LAT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rsp_wr    <= 1'b0;
                        rsp_rdata <= reg_rd_data;
                        state     <= RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboard bench for reg_bus_master: driver pushes expected strobes and
// responses, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_reg_bus_master;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_wr;
    logic [DW-1:0] rsp_rdata;
    logic          reg_rd_en, reg_wr_en;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wr_data, reg_rd_data;

    logic          c1_valid, c1_ready, rsp1_valid, rsp1_wr, rd1_en, wr1_en;
    logic [AW-1:0] addr1;
    logic [DW-1:0] rdata1, wdata1, rdd1;

    always #5 clk = ~clk;

    reg_bus_master #(.ADDR_SZ(AW), .DATA_SZ(DW), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
        .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data)
    );

    reg_bus_master #(.ADDR_SZ(AW), .DATA_SZ(DW), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_wr(1'b0),
        .cmd_addr(8'h08), .cmd_wdata(32'h0),
        .rsp_valid(rsp1_valid), .rsp_ready(1'b1), .rsp_wr(rsp1_wr), .rsp_rdata(rdata1),
        .reg_rd_en(rd1_en), .reg_wr_en(wr1_en), .reg_addr(addr1),
        .reg_wr_data(wdata1), .reg_rd_data(rdd1)
    );

    typedef struct { logic wr; logic [DW-1:0] rdata; int rise; } rsp_t;
    typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } stb_t;

    rsp_t          rsp_q[$];
    stb_t          stb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            hs_edge = 0;
    logic [DW-1:0] exp_mem [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
    endtask

    // Register file model: correct data exactly LAT cycles after the read strobe, garbage otherwise.
    logic [DW-1:0] mem [256];
    logic          hist_v [LAT];
    logic [AW-1:0] hist_a [LAT];
    logic          cur_rd = 1'b0, cur_wr = 1'b0;
    logic [AW-1:0] cur_a = '0;
    logic [DW-1:0] cur_d = '0;
    logic          rd1_q = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        for (int i = 0; i < LAT; i++) begin
            hist_v[i] = 1'b0;
            hist_a[i] = '0;
        end
        reg_rd_data = '0;
        rdd1 = '0;
    end

    always @(negedge clk) begin
        cur_rd = reg_rd_en;
        cur_wr = reg_wr_en;
        cur_a  = reg_addr;
        cur_d  = reg_wr_data;
        rd1_q  = rd1_en;
    end

    always @(posedge clk) begin
        if (cur_wr) mem[cur_a] = cur_d;
        for (int i = LAT - 1; i > 0; i--) begin
            hist_v[i] = hist_v[i-1];
            hist_a[i] = hist_a[i-1];
        end
        hist_v[0] = cur_rd;
        hist_a[0] = cur_a;
        #1;
        reg_rd_data = hist_v[LAT-1] ? mem[hist_a[LAT-1]] : $urandom;
        rdd1 = rd1_q ? 32'hDEAD_BEEF : $urandom;
    end

    // Monitor: strobes and responses checked against the scoreboard queues.
    logic          in_rsp = 1'b0;
    int            rise = 0;
    logic          hold_wr;
    logic [DW-1:0] hold_d;
    stb_t          s;
    rsp_t          r;

    always @(negedge clk) begin
        if (rst) begin
            in_rsp = 1'b0;
        end else begin
            if (reg_rd_en || reg_wr_en) begin
                check("strobe_exclusive", DW'(reg_rd_en & reg_wr_en), '0);
                if (stb_q.size() == 0) begin
                    fail("unexpected_strobe");
                end else begin
                    s = stb_q.pop_front();
                    check("strobe_wr_en", DW'(reg_wr_en), DW'(s.wr));
                    check("strobe_rd_en", DW'(reg_rd_en), DW'(!s.wr));
                    check("strobe_addr", DW'(reg_addr), DW'(s.addr));
                    check("strobe_wdata", reg_wr_data, s.wdata);
                    check("strobe_cycle", DW'(cyc), DW'(s.cyc));
                end
            end
            if (rsp_valid) begin
                check("cmd_ready_in_resp", DW'(cmd_ready), '0);
                if (!in_rsp) begin
                    in_rsp  = 1'b1;
                    rise    = cyc;
                    hold_wr = rsp_wr;
                    hold_d  = rsp_rdata;
                end else begin
                    check("rsp_wr_stable", DW'(rsp_wr), DW'(hold_wr));
                    check("rsp_rdata_stable", rsp_rdata, hold_d);
                end
                if (rsp_ready) begin
                    in_rsp  = 1'b0;
                    hs_edge = cyc + 1;
                    if (rsp_q.size() == 0) begin
                        fail("unexpected_rsp");
                    end else begin
                        r = rsp_q.pop_front();
                        check("rsp_wr", DW'(rsp_wr), DW'(r.wr));
                        check("rsp_rdata", rsp_rdata, r.rdata);
                        check("rsp_rise_cycle", DW'(rise), DW'(r.rise));
                    end
                end
            end
        end
    end

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int e);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            fail("cmd_accept_timeout");
            cmd_valid = 1'b0;
            e = -1;
            return;
        end
        e = cyc + 1;
        stb_q.push_back('{wr, a, wr ? d : {DW{1'b0}}, e});
        rsp_q.push_back('{wr, wr ? {DW{1'b0}} : exp_mem[a], e + 1 + (wr ? 0 : LAT)});
        if (wr) exp_mem[a] = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || stb_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || stb_q.size() != 0) fail("drain_timeout");
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, DW'(rsp_valid), '0);
        check({tag, "_rsp_wr"}, DW'(rsp_wr), '0);
        check({tag, "_rsp_rdata"}, rsp_rdata, '0);
        check({tag, "_reg_rd_en"}, DW'(reg_rd_en), '0);
        check({tag, "_reg_wr_en"}, DW'(reg_wr_en), '0);
        check({tag, "_reg_addr"}, DW'(reg_addr), '0);
        check({tag, "_reg_wr_data"}, reg_wr_data, '0);
        check({tag, "_cmd_ready"}, DW'(cmd_ready), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e2, e1, n;
        logic          w;
        logic [AW-1:0] a;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; c1_valid = 1'b0;

        #1 rst = 1'b1;
        #1 check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("cmd_ready_after_reset", DW'(cmd_ready), 1);

        send(1'b1, 8'h04, 32'h0000_0007, e);
        send(1'b1, 8'h10, 32'hDEAD_BEEF, e);
        send(1'b0, 8'h10, '0, e);
        send(1'b0, 8'h04, '0, e);
        drain();

        // READ_LATENCY=1 instance: response must rise two cycles after the strobe cycle.
        @(negedge clk);
        check("lat1_cmd_ready", DW'(c1_ready), 1);
        c1_valid = 1'b1;
        e1 = cyc + 1;
        @(posedge clk);
        #1 c1_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp1_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp1_valid) fail("lat1_rsp_timeout");
        else begin
            check("lat1_rise_cycle", DW'(cyc), DW'(e1 + 2));
            check("lat1_rdata", rdata1, 32'hDEAD_BEEF);
            check("lat1_rsp_wr", DW'(rsp1_wr), '0);
        end

        // Response backpressure with a second command held on the input.
        rsp_ready = 1'b0;
        send(1'b1, 8'h20, 32'h1234_5678, e);
        fork
            send(1'b0, 8'h20, '0, e2);
            begin
                n = 0;
                while (!rsp_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (!rsp_valid) fail("bp_rsp_timeout");
                repeat (5) @(negedge clk);
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        check("bp_accept_after_handshake", DW'(e2), DW'(hs_edge + 1));
        drain();

        for (int i = 0; i < 20; i++) begin
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 3) * 4);
            send(w, a, $urandom, e);
        end
        drain();

        // Reset while a read is waiting for its data.
        send(1'b0, 8'h10, '0, e);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_in_wait", DW'({rsp_valid, reg_rd_en, cmd_ready}), '0);
        #2 rst = 1'b1;
        #1 check_idle_outputs("reset_wait");
        rsp_q.delete();
        stb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        send(1'b1, 8'h30, 32'hA5A5_0001, e);
        send(1'b0, 8'h30, '0, e);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
